// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined floating-point multiplier with valid/ready handshake
// Optional round-to-nearest-even when FP_MUL_ROUND_EN is defined; truncation otherwise.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] In_A,
  input  logic [W-1:0] In_B,
  input  logic         valid_in,
  output logic         ready_in,
  output logic [W-1:0] Out,
  output logic         valid_out,
  input  logic         ready_out,
  output logic [3:0]   flags
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int P    = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);

  typedef enum logic [1:0] {CL_NUM, CL_ZERO, CL_INF, CL_NAN} cls_e;

  logic stall;
  assign stall    = valid_out && !ready_out;
  assign ready_in = !stall;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign ea = In_A[W-2 -: EXP_W];
  assign eb = In_B[W-2 -: EXP_W];
  assign fa = In_A[MAN_W-1:0];
  assign fb = In_B[MAN_W-1:0];

  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  cls_e                 cls1_d;
  logic                 sign1_d;
  logic signed [EW-1:0] exp1_d;

  // Subnormals (exp==0) are flushed to zero along with true zeros.
  always_comb begin
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    a_inf   = (ea == '1) && (fa == '0);
    b_inf   = (eb == '1) && (fb == '0);
    a_nan   = (ea == '1) && (fa != '0);
    b_nan   = (eb == '1) && (fb != '0);
    sign1_d = In_A[W-1] ^ In_B[W-1];
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) cls1_d = CL_NAN;
    else if (a_inf || b_inf)                                      cls1_d = CL_INF;
    else if (a_zero || b_zero)                                    cls1_d = CL_ZERO;
    else                                                          cls1_d = CL_NUM;
  end

  logic                 v1_q, sign1_q;
  logic signed [EW-1:0] exp1_q;
  logic [MAN_W:0]       man_a1_q, man_b1_q;
  cls_e                 cls1_q;

  logic                 v2_q, sign2_q;
  logic signed [EW-1:0] exp2_q;
  logic [P-1:0]         prod2_q, prod2_d;
  cls_e                 cls2_q;

  logic                 v3_q;
  logic [W-1:0]         out_q, out_d;
  logic [3:0]           flags_q, flags_d;

  assign prod2_d = P'(man_a1_q) * P'(man_b1_q);

  logic                 msb, guard, sticky, carry, inexact;
  logic [MAN_W-1:0]     frac, frac_r;
  logic signed [EW-1:0] exp_f;

  always_comb begin
    msb    = prod2_q[P-1];
    frac   = msb ? prod2_q[P-2 -: MAN_W] : prod2_q[P-3 -: MAN_W];
    guard  = msb ? prod2_q[MAN_W] : prod2_q[MAN_W-1];
    sticky = msb ? |prod2_q[MAN_W-1:0] : |prod2_q[MAN_W-2:0];
`ifdef FP_MUL_ROUND_EN
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
`else
    carry  = 1'b0;
    frac_r = frac;
`endif
    inexact = guard | sticky;
    exp_f   = exp2_q + $signed({{(EW-1){1'b0}}, msb}) + $signed({{(EW-1){1'b0}}, carry});
    out_d   = '0;
    flags_d = '0;
    case (cls2_q)
      CL_NAN: begin
        out_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = 4'b1000;
      end
      CL_INF:  out_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CL_ZERO: out_d = {sign2_q, {(W-1){1'b0}}};
      default: begin
        if (exp_f >= EXP_MAX) begin
          out_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (exp_f <= EXP_ZERO) begin
          out_d   = {sign2_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          out_d   = {sign2_q, exp_f[EXP_W-1:0], frac_r};
          flags_d = {3'b000, inexact};
        end
      end
    endcase
  end

  // Whole pipe advances together; a stall freezes every stage including bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      exp1_q   <= '0;
      man_a1_q <= '0;
      man_b1_q <= '0;
      cls1_q   <= CL_NUM;
      v2_q     <= 1'b0;
      sign2_q  <= 1'b0;
      exp2_q   <= '0;
      prod2_q  <= '0;
      cls2_q   <= CL_NUM;
      v3_q     <= 1'b0;
      out_q    <= '0;
      flags_q  <= '0;
    end else if (!stall) begin
      v1_q     <= valid_in;
      sign1_q  <= sign1_d;
      exp1_q   <= exp1_d;
      man_a1_q <= {1'b1, fa};
      man_b1_q <= {1'b1, fb};
      cls1_q   <= cls1_d;
      v2_q     <= v1_q;
      sign2_q  <= sign1_q;
      exp2_q   <= exp1_q;
      prod2_q  <= prod2_d;
      cls2_q   <= cls1_q;
      v3_q     <= v2_q;
      if (v2_q) begin
        out_q   <= out_d;
        flags_q <= flags_d;
      end
    end
  end

  assign valid_out = v3_q;
  assign Out       = out_q;
  assign flags     = flags_q;

endmodule
